// File: rtl/movavg_pkg.sv
// ============================================================================
// movavg_pkg : shared constants and types for the stereo moving-average filter
// Rev 1.0
// ============================================================================
`default_nettype none

package movavg_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_LOG2_TAPS  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    OUT  = ST_OUT
  } state_e;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  // Sum of 2^lt samples of dw bits never needs more than dw+lt bits.
  function automatic int acc_width(input int dw, input int lt);
    return dw + lt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/movavg_hist.sv
// ============================================================================
// movavg_hist : per-channel sample history, 2 x 2^LOG2_TAPS x DATA_WIDTH RAM,
// synchronous read, read-before-write on a shared address.
// Rev 1.0
// ============================================================================
`default_nettype none

module movavg_hist #(
  parameter int DATA_WIDTH = 24,
  parameter int LOG2_TAPS  = 4
) (
  input  logic                  clk_i,
  input  logic                  rd_en_i,
  input  logic [LOG2_TAPS:0]    rd_addr_i,
  input  logic                  wr_en_i,
  input  logic [LOG2_TAPS:0]    wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**(LOG2_TAPS+1)];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/axis_moving_average.sv
// ============================================================================
// axis_moving_average : stereo boxcar low-pass on a 24-bit AXI-Stream path.
// Optional macro MOVAVG_BYPASS_EN adds a 'bypass' input (raw pass-through).
// Rev 1.0
// ============================================================================
`default_nettype none

module axis_moving_average
  import movavg_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2_TAPS  = DEF_LOG2_TAPS
) (
  input  logic                  axis_clk,
  input  logic                  axis_resetn,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic                  s_axis_last,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last
`ifdef MOVAVG_BYPASS_EN
  ,
  input  logic                  bypass
`endif
);

  localparam int ACC_W = acc_width(DATA_WIDTH, LOG2_TAPS);
  localparam logic [LOG2_TAPS:0] FILL_FULL = {1'b1, {LOG2_TAPS{1'b0}}};

  logic [1:0]              state_q, state_d;
  logic                    s_rdy_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    last_q;
  logic signed [ACC_W-1:0] acc_q [2];
  logic [LOG2_TAPS-1:0]    ptr_q;
  logic [LOG2_TAPS:0]      fill_q;
  logic [DATA_WIDTH-1:0]   mdata_q;
  logic                    mlast_q;

  logic                    accept;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [DATA_WIDTH-1:0]   old_sample;
  logic signed [ACC_W-1:0] new_ext, old_ext, acc_new;
  logic [DATA_WIDTH-1:0]   avg;
  logic [DATA_WIDTH-1:0]   out_word;

  assign accept = s_axis_valid && s_rdy_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_CALC;
      ST_CALC: state_d = ST_OUT;
      ST_OUT:  if (m_axis_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read is issued on the accepting edge so the oldest sample is ready in CALC.
  movavg_hist #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2_TAPS  (LOG2_TAPS)
  ) u_hist (
    .clk_i     (axis_clk),
    .rd_en_i   (accept),
    .rd_addr_i ({s_axis_last, ptr_q}),
    .wr_en_i   (state_q == ST_CALC),
    .wr_addr_i ({last_q, ptr_q}),
    .wr_data_i (data_q),
    .rd_data_o (rd_data)
  );

  assign old_sample = (fill_q < FILL_FULL) ? '0 : rd_data;
  assign new_ext    = {{LOG2_TAPS{data_q[DATA_WIDTH-1]}}, data_q};
  assign old_ext    = {{LOG2_TAPS{old_sample[DATA_WIDTH-1]}}, old_sample};
  assign acc_new    = acc_q[last_q] + new_ext - old_ext;
  // Dropping the low bits is an arithmetic shift rounding toward -inf.
  assign avg        = acc_new[ACC_W-1:LOG2_TAPS];

`ifdef MOVAVG_BYPASS_EN
  logic [1:0] byp_sync_q;

  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) byp_sync_q <= 2'b00;
    else              byp_sync_q <= {byp_sync_q[0], bypass};
  end

  assign out_word = byp_sync_q[1] ? data_q : avg;
`else
  assign out_word = avg;
`endif

  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q     <= ST_IDLE;
      s_rdy_q     <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      acc_q[CH_L] <= '0;
      acc_q[CH_R] <= '0;
      ptr_q       <= '0;
      fill_q      <= '0;
      mdata_q     <= '0;
      mlast_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      s_rdy_q <= (state_d == ST_IDLE);
      if (accept) begin
        data_q <= s_axis_data;
        last_q <= s_axis_last;
      end
      if (state_q == ST_CALC) begin
        acc_q[last_q] <= acc_new;
        mdata_q       <= out_word;
        mlast_q       <= last_q;
        if (last_q) begin
          ptr_q <= ptr_q + 1'b1;
          if (fill_q != FILL_FULL) fill_q <= fill_q + 1'b1;
        end
      end
    end
  end

  assign s_axis_ready = s_rdy_q;
  assign m_axis_valid = (state_q == ST_OUT);
  assign m_axis_data  = mdata_q;
  assign m_axis_last  = mlast_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_moving_average.sv
// ============================================================================
// tb_axis_moving_average : directed + random stimulus against a windowed-sum
// reference model of the stereo moving-average filter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axis_moving_average;

  localparam int DW   = 24;
  localparam int LT   = 4;
  localparam int TAPS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
`ifdef MOVAVG_BYPASS_EN
  logic          byp = 1'b0;
`endif

  int            n_chk = 0;
  int            n_fail = 0;
  int            hist [2][$];
  logic [DW-1:0] last_out [2];

  always #5 clk = ~clk;

  axis_moving_average #(.DATA_WIDTH(DW), .LOG2_TAPS(LT)) dut (
    .axis_clk     (clk),
    .axis_resetn  (rst_n),
    .s_axis_data  (s_data),
    .s_axis_valid (s_valid),
    .s_axis_ready (s_ready),
    .s_axis_last  (s_last),
    .m_axis_data  (m_data),
    .m_axis_valid (m_valid),
    .m_axis_ready (m_ready),
    .m_axis_last  (m_last)
`ifdef MOVAVG_BYPASS_EN
    ,
    .bypass       (byp)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mean of the last TAPS samples of a channel (missing ones count as zero), floored.
  function automatic logic [DW-1:0] model(input int ch, input logic [DW-1:0] d);
    longint s;
    longint a;
    logic [63:0] t;
    int v;
    v = $signed(d);
    hist[ch].push_back(v);
    if (hist[ch].size() > TAPS) void'(hist[ch].pop_front());
    s = 0;
    foreach (hist[ch][i]) s += hist[ch][i];
    if (s >= 0) a = s / TAPS;
    else        a = -((-s + TAPS - 1) / TAPS);
    t = a;
    return t[DW-1:0];
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic l, input int hold, input logic raw);
    logic [DW-1:0] avg;
    logic [DW-1:0] exp;
    int guard;
    avg = model(int'(l), d);
    exp = raw ? d : avg;
    @(negedge clk);
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    m_ready = (hold == 0);
    guard = 0;
    while (!s_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    chk("calc_valid", 32'(m_valid), 32'd0);
    chk("calc_sready", 32'(s_ready), 32'd0);
    @(negedge clk);
    chk("out_valid", 32'(m_valid), 32'd1);
    chk("out_data", 32'(m_data), 32'(exp));
    chk("out_last", 32'(m_last), 32'(l));
    last_out[int'(l)] = m_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(exp));
      chk("hold_last", 32'(m_last), 32'(l));
      chk("hold_sready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("after_valid", 32'(m_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sready", 32'(s_ready), 32'd0);
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_mdata", 32'(m_data), 32'd0);
    chk("rst_mlast", 32'(m_last), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(s_ready), 32'd1);

    // Ramp from empty history
    for (int n = 1; n <= 16; n++) begin
      send(24'h000100, 1'b0, 0, 1'b0);
      send(24'hFFFF00, 1'b1, 0, 1'b0);
    end
    chk("ramp_L_final", 32'(last_out[0]), 32'h000100);
    chk("ramp_R_final", 32'(last_out[1]), 32'hFFFF00);

    // Step on left only
    for (int n = 1; n <= 16; n++) begin
      send(24'h000000, 1'b0, 0, 1'b0);
      send(24'hFFFF00, 1'b1, 0, 1'b0);
      if (n == 1) chk("step_L_first", 32'(last_out[0]), 32'h0000F0);
    end
    chk("step_L_final", 32'(last_out[0]), 32'h000000);
    chk("step_R_final", 32'(last_out[1]), 32'hFFFF00);

    // Backpressure
    send(24'h123456, 1'b0, 50, 1'b0);
    send(24'hFFFF00, 1'b1, 0, 1'b0);

    // Random frames
    for (int n = 0; n < 30; n++) begin
      send(24'($urandom), 1'b0, 0, 1'b0);
      send(24'($urandom), 1'b1, int'($urandom_range(0, 3)), 1'b0);
    end

    // Full scale
    for (int n = 0; n < 16; n++) begin
      send(24'h7FFFFF, 1'b0, 0, 1'b0);
      send(24'h800000, 1'b1, 0, 1'b0);
    end
    chk("fs_pos", 32'(last_out[0]), 32'h7FFFFF);
    chk("fs_neg", 32'(last_out[1]), 32'h800000);

    // Reset during CALC
    @(negedge clk);
    s_data  = 24'h000100;
    s_last  = 1'b0;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_calc_mvalid", 32'(m_valid), 32'd0);
      chk("rst_calc_sready", 32'(s_ready), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rel_mvalid", 32'(m_valid), 32'd0);
    end
    hist[0].delete();
    hist[1].delete();
    send(24'h000100, 1'b0, 0, 1'b0);
    chk("rst_first_L", 32'(last_out[0]), 32'h000010);
    send(24'h000100, 1'b1, 0, 1'b0);
    chk("rst_first_R", 32'(last_out[1]), 32'h000010);

`ifdef MOVAVG_BYPASS_EN
    byp = 1'b1;
    repeat (3) @(negedge clk);
    for (int n = 0; n < 16; n++) begin
      send(24'h000200, 1'b0, 0, 1'b1);
      send(24'h000200, 1'b1, 0, 1'b1);
    end
    byp = 1'b0;
    repeat (3) @(negedge clk);
    send(24'h000200, 1'b0, 0, 1'b0);
    chk("byp_release", 32'(last_out[0]), 32'h000200);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
